// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and the per-channel delay rule for the systolic skew feeder.
package systolic_skew_feeder_pkg;

  typedef enum logic [1:0] {SKW_IDLE, SKW_FEED, SKW_DRAIN} skew_state_e;
  typedef enum logic       {SKEW_FWD, SKEW_REV}            skew_mode_e;

  // Delay in cycles applied to channel k of an n-channel edge.
  // FWD skews operands entering the array, REV undoes that skew on the way out.
  function automatic int skew_delay(input int k, input int n, input int step,
                                    input skew_mode_e mode);
    return (mode == SKEW_REV) ? (n - 1 - k) * step : k * step;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Vector handshake in, skewed per-channel data/valid out.
interface systolic_skew_feeder_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_last;
  logic signed [DATA_WIDTH-1:0] data_in  [ARRAY_SIZE];
  logic signed [DATA_WIDTH-1:0] data_out [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0]        out_valid;

  modport master (output in_valid, in_last, data_in,
                  input  in_ready, data_out, out_valid);
  modport slave  (input  in_valid, in_last, data_in,
                  output in_ready, data_out, out_valid);
endinterface

// File: rtl/systolic_skew_feeder_delay_line.sv
// One channel's {valid,data} shift line. Tap 0 is the (already gated) input
// itself; tap d>0 is the register stage d-1.
module systolic_skew_feeder_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3,
  parameter int TAP_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         advance,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic [TAP_W-1:0]             tap,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  if (DEPTH > 0) begin : g_line
    logic [DEPTH-1:0]             vld_pipe;
    logic signed [DATA_WIDTH-1:0] dat_pipe [DEPTH];

    // Shift line: flush clears, stall holds, otherwise advance one stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
        for (int i = 0; i < DEPTH; i++) dat_pipe[i] <= '0;
      end else if (flush) begin
        vld_pipe <= '0;
        for (int i = 0; i < DEPTH; i++) dat_pipe[i] <= '0;
      end else if (advance) begin
        vld_pipe[0] <= in_valid;
        dat_pipe[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          dat_pipe[i] <= dat_pipe[i-1];
        end
      end
    end

    // Tap select; data forced to zero on invalid slots.
    always_comb begin
      out_valid = in_valid;
      out_data  = in_data;
      for (int i = 1; i <= DEPTH; i++) begin
        if (tap == TAP_W'(i)) begin
          out_valid = vld_pipe[i-1];
          out_data  = vld_pipe[i-1] ? dat_pipe[i-1] : '0;
        end
      end
    end
  end else begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, advance, flush, tap};
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skew/deskew stage for systolic array edges: accepts one N-wide vector per
// cycle, delays channel k by a mode-dependent multiple of SKEW_STEP, drains the
// lines after the last vector and pulses done.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SKEW_STEP  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode_rev,
  input  logic                   flush,
  input  logic                   stall,
  systolic_skew_feeder_if.slave  bus,
  output logic                   busy,
  output logic                   done
);

  localparam int MAX_DELAY = (ARRAY_SIZE - 1) * SKEW_STEP;
  localparam int TAP_W     = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;

  skew_state_e      state, state_nxt;
  skew_mode_e       mode_q, mode_nxt, mode_eff;
  logic [TAP_W-1:0] drain_cnt, cnt_nxt;
  logic             done_pend, done_pend_nxt;
  logic             in_ready, accept, advance;

  assign in_ready     = ((state == SKW_IDLE) || (state == SKW_FEED)) && !stall && !flush;
  assign accept       = bus.in_valid && in_ready;
  assign advance      = !stall;
  assign bus.in_ready = in_ready;
  assign busy         = (state != SKW_IDLE);
  // A pending done waits out any stall.
  assign done         = done_pend && !stall;
  // The first vector of a burst must already use the new mode on its
  // combinational tap, before mode_q has captured it.
  assign mode_eff     = (state == SKW_IDLE && accept) ? skew_mode_e'(mode_rev) : mode_q;

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SKW_IDLE;
      mode_q    <= SKEW_FWD;
      drain_cnt <= '0;
      done_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_nxt;
      drain_cnt <= cnt_nxt;
      done_pend <= done_pend_nxt;
    end
  end

  // Next-state: burst entry/feed, drain countdown, done scheduling.
  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode_q;
    cnt_nxt       = drain_cnt;
    done_pend_nxt = done_pend && stall;
    if (flush) begin
      state_nxt     = SKW_IDLE;
      mode_nxt      = SKEW_FWD;
      cnt_nxt       = '0;
      done_pend_nxt = 1'b0;
    end else begin
      case (state)
        SKW_IDLE, SKW_FEED: begin
          if (accept) begin
            if (state == SKW_IDLE) mode_nxt = skew_mode_e'(mode_rev);
            if (!bus.in_last) begin
              state_nxt = SKW_FEED;
            end else if (MAX_DELAY == 0) begin
              state_nxt     = SKW_IDLE;
              done_pend_nxt = 1'b1;
            end else begin
              state_nxt = SKW_DRAIN;
              cnt_nxt   = TAP_W'(MAX_DELAY);
            end
          end
        end
        SKW_DRAIN: begin
          if (!stall) begin
            if (drain_cnt <= TAP_W'(1)) begin
              state_nxt     = SKW_IDLE;
              cnt_nxt       = '0;
              done_pend_nxt = 1'b1;
            end else begin
              cnt_nxt = drain_cnt - TAP_W'(1);
            end
          end
        end
        default: state_nxt = SKW_IDLE;
      endcase
    end
  end

  // Per-channel delay lines with fixed FWD/REV taps.
  for (genvar k = 0; k < ARRAY_SIZE; k++) begin : g_ch
    localparam int D_FWD = skew_delay(k, ARRAY_SIZE, SKEW_STEP, SKEW_FWD);
    localparam int D_REV = skew_delay(k, ARRAY_SIZE, SKEW_STEP, SKEW_REV);

    logic [TAP_W-1:0]             tap;
    logic signed [DATA_WIDTH-1:0] ch_in;
    logic                         ch_vld;
    logic signed [DATA_WIDTH-1:0] ch_out;

    assign tap   = (mode_eff == SKEW_REV) ? TAP_W'(D_REV) : TAP_W'(D_FWD);
    assign ch_in = accept ? bus.data_in[k] : '0;

    systolic_skew_feeder_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_DELAY),
      .TAP_W      (TAP_W)
    ) u_line (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance),
      .flush     (flush),
      .in_valid  (accept),
      .in_data   (ch_in),
      .tap       (tap),
      .out_valid (ch_vld),
      .out_data  (ch_out)
    );

    assign bus.out_valid[k] = ch_vld;
    assign bus.data_out[k]  = ch_out;
  end

endmodule
